// File: rtl/quadrature_encoder_gen_if.sv
// Step-command channel for quadrature_encoder_gen: signed edge count, edge period,
// valid/ready handshake and the abort strobe.
interface quadrature_encoder_gen_if;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [23:0] cmd_steps;
  logic        [15:0] cmd_period;
  logic               abort;

  modport master (output cmd_valid, cmd_steps, cmd_period, abort, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_steps, cmd_period, abort, output cmd_ready);
endinterface

// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B(/Z) generator driven by signed step commands; inverse of quadrature_decoder.
// Optional index output enabled with `define QUAD_INDEX_EN.
module quadrature_encoder_gen #(
  parameter int MIN_PERIOD     = 2,
  parameter int POS_WIDTH      = 32,
  parameter int COUNTS_PER_REV = 2048
) (
  input  logic                        clk16MHz,
  input  logic                        reset,
  quadrature_encoder_gen_if.slave     cmd,
  output logic                        a,
  output logic                        b,
  output logic                        z,
  output logic                        busy,
  output logic                        done,
  output logic signed [POS_WIDTH-1:0] position
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                      state_q, state_d;
  logic [23:0]                 remaining_q;
  logic [15:0]                 period_q, timer_q;
  logic                        dir_q;
  logic [23:0]                 steps_raw, steps_mag;
  logic [15:0]                 period_eff;
  logic                        accept, edge_due, last_edge;
  logic signed [POS_WIDTH-1:0] pos_next;
  logic [1:0]                  ab_next;

  // Magnitude in unsigned 24 bits so -2^23 maps cleanly to 2^23.
  assign steps_raw  = cmd.cmd_steps;
  assign steps_mag  = steps_raw[23] ? (~steps_raw + 24'd1) : steps_raw;
  assign period_eff = (cmd.cmd_period < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : cmd.cmd_period;

  assign accept    = (state_q == IDLE) && cmd.cmd_valid && !reset;
  assign edge_due  = (state_q == RUN) && (timer_q == 16'd1) && !cmd.abort;
  assign last_edge = edge_due && (remaining_q == 24'd1);
  assign pos_next  = dir_q ? position - POS_WIDTH'(1) : position + POS_WIDTH'(1);

  assign cmd.cmd_ready = (state_q == IDLE) && !reset;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);

  // Gray sequence 00,10,11,01 so exactly one output toggles per edge.
  always_comb begin
    ab_next = 2'b00;
    case (pos_next[1:0])
      2'd0:    ab_next = 2'b00;
      2'd1:    ab_next = 2'b10;
      2'd2:    ab_next = 2'b11;
      default: ab_next = 2'b01;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (steps_mag == 24'd0) ? DONE : RUN;
      RUN: begin
        if (cmd.abort)      state_d = IDLE;
        else if (last_edge) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk16MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      period_q    <= '0;
      timer_q     <= '0;
      dir_q       <= 1'b0;
      position    <= '0;
      a           <= 1'b0;
      b           <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        remaining_q <= steps_mag;
        dir_q       <= steps_raw[23];
        period_q    <= period_eff;
        timer_q     <= period_eff;
      end else if (state_q == RUN) begin
        timer_q <= (timer_q == 16'd1) ? period_q : timer_q - 16'd1;
        if (edge_due) begin
          remaining_q <= remaining_q - 24'd1;
          position    <= pos_next;
          {a, b}      <= ab_next;
        end
      end
    end
  end

`ifdef QUAD_INDEX_EN
  localparam int RW = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;

  logic [RW-1:0] rev_cnt, rev_next;

  always_comb begin
    rev_next = rev_cnt;
    if (dir_q) rev_next = (rev_cnt == '0) ? RW'(COUNTS_PER_REV - 1) : rev_cnt - RW'(1);
    else       rev_next = (rev_cnt == RW'(COUNTS_PER_REV - 1)) ? '0 : rev_cnt + RW'(1);
  end

  // z is registered alongside a/b so it spans exactly the rev_cnt==0 edge period.
  always_ff @(posedge clk16MHz) begin
    if (reset) begin
      rev_cnt <= '0;
      z       <= 1'b1;
    end else if (edge_due) begin
      rev_cnt <= rev_next;
      z       <= (rev_next == '0);
    end
  end
`else
  assign z = 1'b0;
`endif
endmodule
